// File: rtl/ioctl_upload_reader.sv
// rtl/ioctl_upload_reader.sv - serves hps_io upload byte reads from SDRAM words with a one-word prefetch
module ioctl_upload_reader #(
    parameter int unsigned BASE_ADDR        = 0,
    parameter int unsigned SIZE_BYTES       = 'h4000,
    parameter int unsigned SDRAM_ADDR_WIDTH = 23
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        ioctl_upload,
    input  logic                        ioctl_rd,
    input  logic [26:0]                 ioctl_addr,
    output logic [7:0]                  ioctl_din,
    output logic                        ioctl_wait,
    output logic [SDRAM_ADDR_WIDTH-1:0] sdram_addr,
    output logic                        sdram_req,
    input  logic                        sdram_ack,
    input  logic                        sdram_valid,
    input  logic [31:0]                 sdram_q,
    output logic                        busy
);

    typedef enum logic [2:0] {IDLE, DREQ, DWAIT, PREQ, PWAIT} state_t;

    localparam logic [27:0]                 SIZE_LIM = 28'(SIZE_BYTES);
    localparam logic [SDRAM_ADDR_WIDTH-1:0] BASE_W   = SDRAM_ADDR_WIDTH'(BASE_ADDR);

    state_t                      state, state_n;
    logic                        cur_valid, cur_valid_n, nxt_valid, nxt_valid_n;
    logic [24:0]                 cur_tag, cur_tag_n, nxt_tag, nxt_tag_n;
    logic [31:0]                 cur_word, cur_word_n, nxt_word, nxt_word_n;
    logic [24:0]                 req_tag, req_tag_n;
    logic                        pend_valid, pend_valid_n;
    logic [24:0]                 pend_tag, pend_tag_n;
    logic [1:0]                  pend_lane, pend_lane_n;
    logic                        drop, drop_n;
    logic                        upload_d;
    logic [7:0]                  din_q, din_n;
    logic                        wait_q, wait_n;
    logic [SDRAM_ADDR_WIDTH-1:0] addr_q, addr_n;

    logic                        upload_edge, upload_fall;
    logic                        consume, fresh, pend_live, free, rd_ok, rd_oor;
    logic [24:0]                 rd_tag;
    logic [1:0]                  rd_lane;

    function automatic logic [7:0] lane_of(input logic [31:0] w, input logic [1:0] l);
        return w[8*l +: 8];
    endfunction

    // Prefetch target is tag+1; it must start below the image end and only during an upload.
    function automatic logic pf_ok(input logic [24:0] tag, input logic up);
        logic [25:0] next_idx;
        next_idx = {1'b0, tag} + 26'd1;
        return up && ({next_idx, 2'b00} < SIZE_LIM);
    endfunction

    function automatic logic [SDRAM_ADDR_WIDTH-1:0] word_addr(input logic [24:0] tag);
        return BASE_W + SDRAM_ADDR_WIDTH'(tag);
    endfunction

    assign upload_edge = ioctl_upload ^ upload_d;
    assign upload_fall = upload_d & ~ioctl_upload;
    assign rd_tag      = ioctl_addr[26:2];
    assign rd_lane     = ioctl_addr[1:0];
    assign rd_oor      = {1'b0, ioctl_addr} >= SIZE_LIM;

    assign ioctl_din   = din_q;
    assign ioctl_wait  = wait_q & ~upload_fall;
    assign sdram_addr  = addr_q;
    assign sdram_req   = (state == DREQ) || (state == PREQ);
    assign busy        = (state != IDLE);

    always_comb begin
        state_n     = state;
        cur_valid_n = cur_valid;
        cur_tag_n   = cur_tag;
        cur_word_n  = cur_word;
        nxt_valid_n = nxt_valid;
        nxt_tag_n   = nxt_tag;
        nxt_word_n  = nxt_word;
        req_tag_n   = req_tag;
        pend_valid_n = pend_valid;
        pend_tag_n  = pend_tag;
        pend_lane_n = pend_lane;
        drop_n      = drop;
        din_n       = din_q;
        wait_n      = wait_q;
        addr_n      = addr_q;
        free        = 1'b0;
        consume     = sdram_valid && ((state == DWAIT) || (state == PWAIT));
        fresh       = !drop && !upload_edge;
        pend_live   = pend_valid && !upload_edge;
        rd_ok       = ioctl_rd && !ioctl_wait && !upload_edge;

        // Completion of the outstanding SDRAM transaction is resolved first so the
        // read hit test below sees the freshly captured word.
        case (state)
            IDLE: free = 1'b1;
            DREQ: if (sdram_ack) state_n = DWAIT;
            PREQ: if (sdram_ack) state_n = PWAIT;
            DWAIT, PWAIT: begin
                if (sdram_valid) begin
                    drop_n = 1'b0;
                    if (pend_live && fresh && (req_tag == pend_tag)) begin
                        cur_valid_n  = 1'b1;
                        cur_tag_n    = req_tag;
                        cur_word_n   = sdram_q;
                        if (state == PWAIT) nxt_valid_n = 1'b0;
                        din_n        = lane_of(sdram_q, pend_lane);
                        wait_n       = 1'b0;
                        pend_valid_n = 1'b0;
                        if (pf_ok(req_tag, ioctl_upload)) begin
                            state_n   = PREQ;
                            req_tag_n = req_tag + 25'd1;
                            addr_n    = word_addr(req_tag + 25'd1);
                        end else begin
                            state_n   = IDLE;
                        end
                    end else if (pend_live) begin
                        // Wrong word or stale data: drop it and fetch what the host is waiting for.
                        state_n   = DREQ;
                        req_tag_n = pend_tag;
                        addr_n    = word_addr(pend_tag);
                    end else begin
                        if ((state == PWAIT) && fresh) begin
                            nxt_valid_n = 1'b1;
                            nxt_tag_n   = req_tag;
                            nxt_word_n  = sdram_q;
                        end
                        state_n = IDLE;
                        free    = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (rd_ok) begin
            if (rd_oor) begin
                din_n  = 8'hFF;
                wait_n = 1'b0;
            end else if (cur_valid_n && (cur_tag_n == rd_tag)) begin
                din_n  = lane_of(cur_word_n, rd_lane);
                wait_n = 1'b0;
            end else if (nxt_valid_n && (nxt_tag_n == rd_tag)) begin
                din_n       = lane_of(nxt_word_n, rd_lane);
                wait_n      = 1'b0;
                cur_valid_n = 1'b1;
                cur_tag_n   = nxt_tag_n;
                cur_word_n  = nxt_word_n;
                nxt_valid_n = 1'b0;
                if (free && pf_ok(rd_tag, ioctl_upload)) begin
                    state_n   = PREQ;
                    req_tag_n = rd_tag + 25'd1;
                    addr_n    = word_addr(rd_tag + 25'd1);
                end
            end else begin
                wait_n       = 1'b1;
                pend_valid_n = 1'b1;
                pend_tag_n   = rd_tag;
                pend_lane_n  = rd_lane;
                if (free) begin
                    state_n   = DREQ;
                    req_tag_n = rd_tag;
                    addr_n    = word_addr(rd_tag);
                end
            end
        end

        // Upload boundaries poison everything buffered; an in-flight access runs to completion.
        if (upload_edge) begin
            cur_valid_n  = 1'b0;
            nxt_valid_n  = 1'b0;
            pend_valid_n = 1'b0;
            wait_n       = 1'b0;
            if ((state != IDLE) && !consume) drop_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cur_valid  <= 1'b0;
            cur_tag    <= '0;
            cur_word   <= '0;
            nxt_valid  <= 1'b0;
            nxt_tag    <= '0;
            nxt_word   <= '0;
            req_tag    <= '0;
            pend_valid <= 1'b0;
            pend_tag   <= '0;
            pend_lane  <= '0;
            drop       <= 1'b0;
            upload_d   <= 1'b0;
            din_q      <= 8'h00;
            wait_q     <= 1'b0;
            addr_q     <= '0;
        end else begin
            state      <= state_n;
            cur_valid  <= cur_valid_n;
            cur_tag    <= cur_tag_n;
            cur_word   <= cur_word_n;
            nxt_valid  <= nxt_valid_n;
            nxt_tag    <= nxt_tag_n;
            nxt_word   <= nxt_word_n;
            req_tag    <= req_tag_n;
            pend_valid <= pend_valid_n;
            pend_tag   <= pend_tag_n;
            pend_lane  <= pend_lane_n;
            drop       <= drop_n;
            upload_d   <= ioctl_upload;
            din_q      <= din_n;
            wait_q     <= wait_n;
            addr_q     <= addr_n;
        end
    end

endmodule
